// File: rtl/mem_req_initiator_pkg.sv
// Shared widths and encodings for the single-beat memory request/response interface.
// Count and code encodings are common to every initiator and responder on the bus.
package mem_req_initiator_pkg;

    localparam int ADDR_W      = 32;
    localparam int WORD_W      = 32;
    localparam int MEM_COUNT_W = 2;
    localparam int MEM_CODE_W  = 3;

    typedef enum logic [MEM_COUNT_W-1:0] {
        MEM_COUNT_NONE = 2'd0,
        MEM_COUNT_BYTE = 2'd1,
        MEM_COUNT_HALF = 2'd2,
        MEM_COUNT_WORD = 2'd3
    } mem_count_e;

    // TIMEOUT is produced only by initiators; responders never return it.
    typedef enum logic [MEM_CODE_W-1:0] {
        MEM_CODE_INVALID    = 3'd0,
        MEM_CODE_READ       = 3'd1,
        MEM_CODE_WRITE      = 3'd2,
        MEM_CODE_MISALIGNED = 3'd3,
        MEM_CODE_TIMEOUT    = 3'd4
    } mem_code_e;

endpackage

// File: rtl/mem_load_extend.sv
// Combinational load-data extension: selects the low byte/half/word of a
// right-aligned raw word and sign- or zero-extends it to a full word.
module mem_load_extend
    import mem_req_initiator_pkg::*;
(
    input  logic [MEM_COUNT_W-1:0] count_i,
    input  logic                   signed_i,
    input  logic [WORD_W-1:0]      data_i,
    output logic [WORD_W-1:0]      data_o
);

    // NOTE: every output of an always_comb gets a default before the case so no latch is inferred.
    always_comb begin
        data_o = data_i;
        case (count_i)
            MEM_COUNT_BYTE: data_o = {{(WORD_W-8){signed_i & data_i[7]}}, data_i[7:0]};
            MEM_COUNT_HALF: data_o = {{(WORD_W-16){signed_i & data_i[15]}}, data_i[15:0]};
            default:        data_o = data_i;
        endcase
    end

endmodule

// File: rtl/mem_req_initiator.sv
// Initiator side of the single-beat memory interface: accepts one load/store,
// issues a one-cycle request, waits (with timeout) and returns a done pulse.
module mem_req_initiator
    import mem_req_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 8,
    parameter int CNT_W          = 8
) (
    input  logic                   clk,
    input  logic                   aresetn,

    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic [ADDR_W-1:0]      i_cmd_addr,
    input  logic [WORD_W-1:0]      i_cmd_wr_data,
    input  logic                   i_cmd_wr_en,
    input  logic [MEM_COUNT_W-1:0] i_cmd_count,
    input  logic                   i_cmd_signed,

    output logic [ADDR_W-1:0]      o_req_addr,
    output logic [WORD_W-1:0]      o_req_wr_data,
    output logic                   o_req_wr_en,
    output logic [MEM_COUNT_W-1:0] o_req_count,

    input  logic [WORD_W-1:0]      i_res_rd_data,
    input  logic [MEM_CODE_W-1:0]  i_res_code,

    output logic                   o_done,
    output logic [WORD_W-1:0]      o_rd_data,
    output logic [MEM_CODE_W-1:0]  o_code
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e                 state_q,       state_d;
    logic [ADDR_W-1:0]      req_addr_q,    req_addr_d;
    logic [WORD_W-1:0]      req_wr_data_q, req_wr_data_d;
    logic                   req_wr_en_q,   req_wr_en_d;
    logic [MEM_COUNT_W-1:0] req_count_q,   req_count_d;
    logic [MEM_COUNT_W-1:0] cmd_count_q,   cmd_count_d;
    logic                   cmd_signed_q,  cmd_signed_d;
    logic [CNT_W-1:0]       cnt_q,         cnt_d;
    logic                   done_q,        done_d;
    logic [WORD_W-1:0]      rd_data_q,     rd_data_d;
    logic [MEM_CODE_W-1:0]  code_q,        code_d;

    logic [WORD_W-1:0]      ext_data;

    // Size and signedness are kept apart from req_count_q, which drops to NONE after REQ.
    mem_load_extend u_load_extend (
        .count_i  (cmd_count_q),
        .signed_i (cmd_signed_q),
        .data_i   (i_res_rd_data),
        .data_o   (ext_data)
    );

    always_comb begin
        state_d       = state_q;
        req_addr_d    = req_addr_q;
        req_wr_data_d = req_wr_data_q;
        req_wr_en_d   = req_wr_en_q;
        req_count_d   = req_count_q;
        cmd_count_d   = cmd_count_q;
        cmd_signed_d  = cmd_signed_q;
        cnt_d         = cnt_q;
        done_d        = 1'b0;
        rd_data_d     = rd_data_q;
        code_d        = code_q;

        case (state_q)
            IDLE: begin
                if (i_cmd_valid && (i_cmd_count != MEM_COUNT_NONE)) begin
                    req_addr_d    = i_cmd_addr;
                    req_wr_data_d = i_cmd_wr_data;
                    req_wr_en_d   = i_cmd_wr_en;
                    req_count_d   = i_cmd_count;
                    cmd_count_d   = i_cmd_count;
                    cmd_signed_d  = i_cmd_signed;
                    state_d       = REQ;
                end
            end
            REQ: begin
                req_count_d = MEM_COUNT_NONE;
                state_d     = WAIT;
            end
            WAIT: begin
                if (i_res_code != MEM_CODE_INVALID) begin
                    code_d    = i_res_code;
                    rd_data_d = (i_res_code == MEM_CODE_READ) ? ext_data : '0;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                        code_d    = MEM_CODE_TIMEOUT;
                        rd_data_d = '0;
                        done_d    = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            req_addr_q    <= '0;
            req_wr_data_q <= '0;
            req_wr_en_q   <= 1'b0;
            req_count_q   <= MEM_COUNT_NONE;
            cmd_count_q   <= MEM_COUNT_NONE;
            cmd_signed_q  <= 1'b0;
            cnt_q         <= '0;
            done_q        <= 1'b0;
            rd_data_q     <= '0;
            code_q        <= MEM_CODE_INVALID;
        end else begin
            state_q       <= state_d;
            req_addr_q    <= req_addr_d;
            req_wr_data_q <= req_wr_data_d;
            req_wr_en_q   <= req_wr_en_d;
            req_count_q   <= req_count_d;
            cmd_count_q   <= cmd_count_d;
            cmd_signed_q  <= cmd_signed_d;
            cnt_q         <= cnt_d;
            done_q        <= done_d;
            rd_data_q     <= rd_data_d;
            code_q        <= code_d;
        end
    end

    assign o_cmd_ready   = (state_q == IDLE);
    assign o_req_addr    = req_addr_q;
    assign o_req_wr_data = req_wr_data_q;
    assign o_req_wr_en   = req_wr_en_q;
    assign o_req_count   = req_count_q;
    assign o_done        = done_q;
    assign o_rd_data     = rd_data_q;
    assign o_code        = code_q;

endmodule

// File: tb/tb_mem_req_initiator.sv
// Directed bench for mem_req_initiator with a small behavioural responder
// whose answer latency and stuck-at-INVALID behaviour are set per step.
module tb_mem_req_initiator;
    import mem_req_initiator_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [31:0] i_cmd_addr;
    logic [31:0] i_cmd_wr_data;
    logic        i_cmd_wr_en;
    logic [1:0]  i_cmd_count;
    logic        i_cmd_signed;
    logic [31:0] o_req_addr;
    logic [31:0] o_req_wr_data;
    logic        o_req_wr_en;
    logic [1:0]  o_req_count;
    logic [31:0] i_res_rd_data;
    logic [2:0]  i_res_code;
    logic        o_done;
    logic [31:0] o_rd_data;
    logic [2:0]  o_code;

    always #5 clk = ~clk;

    mem_req_initiator #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_addr    (i_cmd_addr),
        .i_cmd_wr_data (i_cmd_wr_data),
        .i_cmd_wr_en   (i_cmd_wr_en),
        .i_cmd_count   (i_cmd_count),
        .i_cmd_signed  (i_cmd_signed),
        .o_req_addr    (o_req_addr),
        .o_req_wr_data (o_req_wr_data),
        .o_req_wr_en   (o_req_wr_en),
        .o_req_count   (o_req_count),
        .i_res_rd_data (i_res_rd_data),
        .i_res_code    (i_res_code),
        .o_done        (o_done),
        .o_rd_data     (o_rd_data),
        .o_code        (o_code)
    );

    // Responder: latency 0 answers in the first WAIT cycle; garbage data on non-read codes.
    int          rsp_lat = 0;
    bit          stuck = 1'b0;
    logic [31:0] rsp_rd_data = 32'h0;
    logic [31:0] resp_reg = 32'h0;
    int          beats = 0;
    int          wr_beats = 0;
    bit          pend = 1'b0;
    int          dly = 0;
    logic [2:0]  pcode;
    logic [31:0] pdata;
    logic [2:0]  pc;
    logic [31:0] pd;
    bit          mis;

    always @(posedge clk) begin
        i_res_code <= MEM_CODE_INVALID;
        if (pend) begin
            if (dly == 0) begin
                i_res_code    <= pcode;
                i_res_rd_data <= pdata;
                pend = 1'b0;
            end else begin
                dly = dly - 1;
            end
        end
        if (o_req_count != MEM_COUNT_NONE) begin
            beats = beats + 1;
            mis = (o_req_count == MEM_COUNT_HALF && o_req_addr[0]) ||
                  (o_req_count == MEM_COUNT_WORD && o_req_addr[1:0] != 2'b00);
            if (mis) begin
                pc = MEM_CODE_MISALIGNED;
                pd = 32'hAAAA_AAAA;
            end else if (o_req_wr_en) begin
                wr_beats = wr_beats + 1;
                if (o_req_addr == 32'h2000) resp_reg = o_req_wr_data;
                pc = MEM_CODE_WRITE;
                pd = 32'h5555_5555;
            end else begin
                pc = MEM_CODE_READ;
                pd = (o_req_addr == 32'h2000) ? resp_reg : rsp_rd_data;
            end
            if (!stuck) begin
                if (rsp_lat == 0) begin
                    i_res_code    <= pc;
                    i_res_rd_data <= pd;
                end else begin
                    pend  = 1'b1;
                    dly   = rsp_lat - 1;
                    pcode = pc;
                    pdata = pd;
                end
            end
        end
    end

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one command and follows it to o_done (bounded); scrambles i_cmd_* after acceptance.
    task automatic run_cmd(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                           input logic [1:0] cnt, input logic sgn,
                           output int lat, output int req_cycles, output int rdy_hi,
                           output logic [31:0] rd, output logic [2:0] code,
                           output logic [31:0] seen_addr);
        @(negedge clk);
        i_cmd_valid   = 1'b1;
        i_cmd_addr    = addr;
        i_cmd_wr_data = wdata;
        i_cmd_wr_en   = wr;
        i_cmd_count   = cnt;
        i_cmd_signed  = sgn;
        lat = 0; req_cycles = 0; rdy_hi = 0; seen_addr = 32'h0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                i_cmd_valid   = 1'b0;
                i_cmd_addr    = ~addr;
                i_cmd_wr_data = ~wdata;
                i_cmd_wr_en   = ~wr;
                i_cmd_signed  = ~sgn;
            end
            if (o_req_count != MEM_COUNT_NONE) begin
                req_cycles++;
                seen_addr = o_req_addr;
            end
            if (o_cmd_ready) rdy_hi++;
        end while (!o_done && lat < 40);
        rd   = o_rd_data;
        code = o_code;
    endtask

    initial begin
        int          lat, rq, rh, k, nd, wb0, lat1, lat2;
        logic [31:0] rd, sa, rd1, rd2;
        logic [2:0]  cd;

        aresetn = 1'b0; i_cmd_valid = 1'b0; i_cmd_addr = '0; i_cmd_wr_data = '0;
        i_cmd_wr_en = 1'b0; i_cmd_count = MEM_COUNT_NONE; i_cmd_signed = 1'b0;
        i_res_rd_data = '0;
        repeat (3) @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_ready", 32'(o_cmd_ready), 32'd1);
        check("rst_req_count", 32'(o_req_count), 32'(MEM_COUNT_NONE));
        check("rst_req_addr", o_req_addr, 32'h0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_rd_data", o_rd_data, 32'h0);
        check("rst_code", 32'(o_code), 32'(MEM_CODE_INVALID));

        // Valid with NONE is not accepted
        i_cmd_valid = 1'b1; i_cmd_count = MEM_COUNT_NONE; i_cmd_addr = 32'h40;
        rq = 0; rh = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_req_count != MEM_COUNT_NONE) rq++;
            if (o_cmd_ready) rh++;
        end
        i_cmd_valid = 1'b0;
        check("none_req_cycles", 32'(rq), 32'd0);
        check("none_ready_cycles", 32'(rh), 32'd4);

        // Signed byte load
        rsp_lat = 0; rsp_rd_data = 32'h0000_00F0;
        run_cmd(32'h1001, 32'h0, 1'b0, MEM_COUNT_BYTE, 1'b1, lat, rq, rh, rd, cd, sa);
        check("sbyte_latency", 32'(lat), 32'd3);
        check("sbyte_data", rd, 32'hFFFF_FFF0);
        check("sbyte_code", 32'(cd), 32'(MEM_CODE_READ));
        check("sbyte_req_cycles", 32'(rq), 32'd1);
        check("sbyte_req_addr", sa, 32'h1001);
        check("sbyte_ready_low", 32'(rh), 32'd0);
        @(negedge clk);
        check("sbyte_done_one_cycle", 32'(o_done), 32'd0);
        check("sbyte_data_hold", o_rd_data, 32'hFFFF_FFF0);
        check("sbyte_code_hold", 32'(o_code), 32'(MEM_CODE_READ));

        // Half loads, unsigned and signed
        rsp_rd_data = 32'h0000_8001;
        run_cmd(32'h1002, 32'h0, 1'b0, MEM_COUNT_HALF, 1'b0, lat, rq, rh, rd, cd, sa);
        check("uhalf_data", rd, 32'h0000_8001);
        run_cmd(32'h1002, 32'h0, 1'b0, MEM_COUNT_HALF, 1'b1, lat, rq, rh, rd, cd, sa);
        check("shalf_data", rd, 32'hFFFF_8001);

        // Unsigned byte ignores upper raw bits
        rsp_rd_data = 32'h1234_56F0;
        run_cmd(32'h1003, 32'h0, 1'b0, MEM_COUNT_BYTE, 1'b0, lat, rq, rh, rd, cd, sa);
        check("ubyte_data", rd, 32'h0000_00F0);

        // Word store
        wb0 = wr_beats;
        run_cmd(32'h2000, 32'hDEAD_BEEF, 1'b1, MEM_COUNT_WORD, 1'b0, lat, rq, rh, rd, cd, sa);
        check("store_code", 32'(cd), 32'(MEM_CODE_WRITE));
        check("store_data_zero", rd, 32'h0);
        check("store_beats", 32'(wr_beats - wb0), 32'd1);
        check("store_resp_reg", resp_reg, 32'hDEAD_BEEF);

        // Misaligned word
        run_cmd(32'h2002, 32'h0, 1'b0, MEM_COUNT_WORD, 1'b0, lat, rq, rh, rd, cd, sa);
        check("mis_code", 32'(cd), 32'(MEM_CODE_MISALIGNED));
        check("mis_data_zero", rd, 32'h0);

        // Timeout with a stuck responder
        stuck = 1'b1;
        run_cmd(32'h3000, 32'h0, 1'b0, MEM_COUNT_WORD, 1'b0, lat, rq, rh, rd, cd, sa);
        stuck = 1'b0;
        check("to_latency", 32'(lat), 32'(TO + 2));
        check("to_code", 32'(cd), 32'(MEM_CODE_TIMEOUT));
        check("to_data_zero", rd, 32'h0);

        // Answer on WAIT cycle 5: no timeout
        rsp_lat = 4; rsp_rd_data = 32'h0000_0077;
        run_cmd(32'h3004, 32'h0, 1'b0, MEM_COUNT_WORD, 1'b0, lat, rq, rh, rd, cd, sa);
        check("late5_latency", 32'(lat), 32'd7);
        check("late5_code", 32'(cd), 32'(MEM_CODE_READ));
        check("late5_data", rd, 32'h0000_0077);

        // Reset during WAIT; late response must be ignored
        rsp_lat = 6;
        @(negedge clk);
        i_cmd_valid = 1'b1; i_cmd_addr = 32'h3008; i_cmd_wr_en = 1'b0;
        i_cmd_count = MEM_COUNT_WORD; i_cmd_signed = 1'b0;
        @(negedge clk);
        i_cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        aresetn = 1'b0;
        @(negedge clk);
        aresetn = 1'b1;
        check("mrst_ready", 32'(o_cmd_ready), 32'd1);
        check("mrst_req_count", 32'(o_req_count), 32'(MEM_COUNT_NONE));
        check("mrst_done", 32'(o_done), 32'd0);
        check("mrst_code", 32'(o_code), 32'(MEM_CODE_INVALID));
        nd = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_done) nd++;
        end
        check("mrst_late_ignored", 32'(nd), 32'd0);
        check("mrst_code_after", 32'(o_code), 32'(MEM_CODE_INVALID));
        check("mrst_idle_after", 32'(o_cmd_ready), 32'd1);

        // Back-to-back with valid held high: store readback, then second load
        rsp_lat = 0; rsp_rd_data = 32'h1234_5678;
        @(negedge clk);
        i_cmd_valid = 1'b1; i_cmd_addr = 32'h2000; i_cmd_wr_en = 1'b0;
        i_cmd_count = MEM_COUNT_WORD; i_cmd_signed = 1'b0;
        k = 0; nd = 0; rq = 0; lat1 = 0; lat2 = 0; rd1 = '0; rd2 = '0;
        while (nd < 2 && k < 40) begin
            @(negedge clk);
            k++;
            if (k == 1) i_cmd_addr = 32'h3000;
            if (k == 5) i_cmd_valid = 1'b0;
            if (o_req_count != MEM_COUNT_NONE) rq++;
            if (o_done) begin
                nd++;
                if (nd == 1) begin lat1 = k; rd1 = o_rd_data; end
                else         begin lat2 = k; rd2 = o_rd_data; end
            end
        end
        check("b2b_first_latency", 32'(lat1), 32'd3);
        check("b2b_first_data", rd1, 32'hDEAD_BEEF);
        check("b2b_second_latency", 32'(lat2), 32'd7);
        check("b2b_second_data", rd2, 32'h1234_5678);
        check("b2b_req_cycles", 32'(rq), 32'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_req_initiator.md
Name: mem_req_initiator

Overview:
- Initiator (master) side of the single-beat memory request/response interface used by the memory peripherals.
- Accepts one load/store command at a time from the CPU load/store stage and drives the request for exactly one cycle.
- Waits for a valid response code, with a timeout; sign/zero-extends load data.
- Returns a one-cycle completion pulse with data and code to the pipeline.

Parameters:
- TIMEOUT_CYCLES, 8, maximum WAIT cycles without a valid response code before the access is aborted; legal range 1..255.
- CNT_W, 8, width of the internal wait counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- aresetn  in  1  reset, synchronous, active-low
- i_cmd_valid  in  1  command present; accepted when o_cmd_ready=1
- o_cmd_ready  out  1  high only in IDLE
- i_cmd_addr  in  `ADDR_W  byte address
- i_cmd_wr_data  in  `WORD_W  store data, right-aligned
- i_cmd_wr_en  in  1  1=store, 0=load
- i_cmd_count  in  `MEM_COUNT_W  BYTE/HALF/WORD; NONE with valid is ignored (not accepted)
- i_cmd_signed  in  1  load sign-extend enable
- o_req_addr  out  `ADDR_W  request address
- o_req_wr_data  out  `WORD_W  request write data
- o_req_wr_en  out  1  request direction
- o_req_count  out  `MEM_COUNT_W  request size; `MEM_COUNT_NONE when idle
- i_res_rd_data  in  `WORD_W  responder read data, right-aligned
- i_res_code  in  `MEM_CODE_W  responder code
- o_done  out  1  one-cycle completion pulse
- o_rd_data  out  `WORD_W  extended load data, valid with o_done
- o_code  out  `MEM_CODE_W  final code, valid with o_done

Behaviour:
- One clock; reset is synchronous and active-low.
- On clk edge with aresetn=0:
  - state goes to IDLE.
  - o_req_count=`MEM_COUNT_NONE; o_req_addr, o_req_wr_data, o_req_wr_en = 0.
  - o_done=0, o_rd_data=0, o_code=`MEM_CODE_INVALID, counter=0.
  - Applies mid-operation: any in-flight response is discarded.
- All outputs are registered except o_cmd_ready, which is decoded from state.
- IDLE:
  - o_cmd_ready=1.
  - On i_cmd_valid=1 with count != NONE: latch addr, wr_data, wr_en, count, signed; drive request registers; go to REQ.
- REQ (exactly 1 cycle): request visible on o_req_*; next state WAIT; o_req_count returns to NONE at the same edge, so the responder never executes a command twice.
- WAIT:
  - Each cycle, sample i_res_code.
  - If != `MEM_CODE_INVALID: capture code and data; go to DONE.
  - Else increment counter. When counter reaches TIMEOUT_CYCLES: code=`MEM_CODE_TIMEOUT, data=0; go to DONE.
  - A zero-latency-registered responder answers in the first WAIT cycle.
- DONE (1 cycle):
  - o_done=1 with o_rd_data and o_code; counter cleared; next IDLE.
  - o_done=0 in all other states; o_rd_data and o_code hold their last values.
- Command-to-done latency: accept edge, REQ, WAIT (≥1), DONE. Minimum 3 cycles after acceptance; o_cmd_ready is low throughout.
- Data rules on code = READ:
  - BYTE: bits [7:0], extended from bit 7 if signed, else zero.
  - HALF: bits [15:0], extended from bit 15 if signed, else zero.
  - WORD: passthrough.
- Data on codes WRITE, MISALIGNED, INVALID or TIMEOUT: o_rd_data=0.
- Misalignment is detected by the responder only; the initiator forwards the code unchanged.
- Unexpected code (e.g. READ returned for a store) is passed through unchanged.
- i_cmd_* changes after acceptance have no effect.

Decomposition:
- mem_codes.vh: add `MEM_CODE_TIMEOUT, distinct from the existing codes.
- Widths come from config.vh (`ADDR_W, `WORD_W); count/code encodings come from mem_codes.vh.
- State encoding stays local (localparam IDLE/REQ/WAIT/DONE).
- One combinational sub-module, mem_load_extend, with inputs count, signed and raw data, and output the extended word. It is reused by future cached load paths.

Test Plan:
- Signed byte load:
  - Stimulus: addr 0x1001, BYTE, signed=1; responder returns READ with data 0x000000F0.
  - Required: o_done exactly 3 cycles after accept; o_rd_data=0xFFFFFFF0; o_code=READ; o_req_count=BYTE for exactly one cycle.
- Unsigned half load: HALF, signed=0; responder returns 0x00008001 → o_rd_data=0x00008001. Same access with signed=1 → 0xFFFF8001.
- Word store: addr 0x2000, data 0xDEADBEEF; responder returns WRITE → o_rd_data=0; o_code=WRITE; responder register reads back 0xDEADBEEF; only one write beat is issued.
- Misaligned: WORD at 0x2002 → o_code=MISALIGNED; o_rd_data=0.
- Timeout: responder stuck at INVALID, TIMEOUT_CYCLES=8 → o_done 10 cycles after accept; o_code=TIMEOUT. A responder answering on WAIT cycle 5 gives its code with no timeout.
- Reset during WAIT, then back-to-back commands:
  - On reset: next cycle IDLE, o_req_count=NONE, o_done=0, and a late response is ignored.
  - i_cmd_valid held high for two commands: the second is accepted only after DONE, and each completes with its own data.
